// File: rtl/fetch_unit.sv
// fetch_unit: owns the architectural PC, fetches 16-bit instruction words over a
// req/gnt/rvalid memory interface (one request outstanding at most) and hands
// each word with its PC and PC+2 to IF/ID over valid/ready. Redirects flush any
// in-flight fetch; a delivered HLT parks the unit until the next redirect.
// Optional feature: define IFETCH_STATS_EN to add saturating transfer/flush
// counters (stat_fetched, stat_flushed).
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0] stat_fetched,
  output logic [15:0] stat_flushed
`endif
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] req_pc_reg, req_pc_next;
  logic        drop_reg, drop_next;
  logic        capture;
  logic        transfer;
  logic        is_hlt;

  // Redirects forbid a transfer in the same cycle, so valid is gated combinationally.
  assign if_valid  = (state_reg == S_HOLD) && !redirect;
  assign transfer  = if_valid && if_ready;
  assign is_hlt    = (if_instr[15:12] == HLT_OPCODE);
  // Request is masked while reset is held so nothing escapes during reset.
  assign imem_req  = rst_n && (state_reg == S_FETCH);
  assign imem_addr = pc_reg;
  assign halted    = (state_reg == S_HALTED);

  // Next-state, PC and drop-flag logic; redirect overrides everything last.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    drop_next   = drop_reg;
    capture     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (imem_gnt) begin
          req_pc_next = pc_reg;
          state_next  = S_WAIT;
          // Granted request now targets the old stream; its reply must be discarded.
          if (redirect) drop_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_reg || redirect) begin
            drop_next  = 1'b0;
            state_next = S_FETCH;
          end else begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end
        end else if (redirect) begin
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (transfer) begin
          if (is_hlt) begin
            state_next = S_HALTED;
          end else begin
            pc_next    = if_pc + 16'd2;
            state_next = S_FETCH;
          end
        end else if (redirect) begin
          state_next = S_FETCH;
        end
      end
      S_HALTED: begin
        if (redirect) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    if (redirect) pc_next = {redirect_pc[15:1], 1'b0};
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= 16'h0000;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      drop_reg   <= drop_next;
    end
  end

  // IF/ID output buffer: loaded on an accepted response, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
    end else if (capture) begin
      if_instr    <= imem_rdata;
      if_pc       <= req_pc_reg;
      if_pc_plus2 <= req_pc_reg + 16'd2;
    end
  end

`ifdef IFETCH_STATS_EN
  logic flush_evt;

  // A flush is a discarded response or an abandoned buffered instruction.
  assign flush_evt = ((state_reg == S_WAIT) && imem_rvalid && (drop_reg || redirect))
                   || ((state_reg == S_HOLD) && redirect);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= 16'h0000;
      stat_flushed <= 16'h0000;
    end else begin
      if (transfer && (stat_fetched != 16'hFFFF)) stat_fetched <= stat_fetched + 16'd1;
      if (flush_evt && (stat_flushed != 16'hFFFF)) stat_flushed <= stat_flushed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit, checked
// against a stream-level reference model (next expected PC, halt flag and a
// fixed address->word memory image).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  logic [15:0] exp_pc;
  logic        exp_halted;
  // Memory responder state.
  bit          outstanding;
  bit          stray;
  logic [15:0] out_addr;
  int          lat_left;
  int          lat_min;
  int          lat_max;
  int          gnt_pct;
  bit          last_grant;
  // Throughput bookkeeping.
  int          cyc;
  int          last_xfer;
  bit          cadence_on;
  int          n_xfer;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory image: word depends only on address; 0x..7E style addresses hold HLT.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] op;
    op = a[4:1] ^ a[15:12];
    if (op == 4'hF) op = 4'h7;
    if (a[7:1] == 7'h3F) op = 4'hF;
    return {op, a[11:0] ^ 12'h5A5};
  endfunction

  // One clock: drive inputs at negedge, sample #1 later, update the model.
  task automatic cycle(input logic rd, input logic [15:0] rpc, input logic rdy);
    bit xfer;
    bit grant;
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rpc;
    if_ready    = rdy;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'($urandom);
    imem_gnt    = 1'b0;
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
      stray       = 1'b0;
    end else begin
      if (outstanding) begin
        if (lat_left == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(out_addr);
          outstanding = 1'b0;
        end else begin
          lat_left--;
        end
      end
      if (imem_req && ($urandom_range(0, 99) < gnt_pct)) imem_gnt = 1'b1;
    end
    #1;
    xfer  = if_valid && if_ready;
    grant = imem_req && imem_gnt;
    last_grant = grant;
    check("halted", 16'(halted), 16'(exp_halted));
    if (exp_halted) begin
      check("halt_noreq", 16'(imem_req), 16'h0);
      check("halt_novalid", 16'(if_valid), 16'h0);
    end
    if (rd) check("redirect_gate", 16'(if_valid), 16'h0);
    if (grant) begin
      check("fetch_addr", imem_addr, exp_pc);
      outstanding = 1'b1;
      out_addr    = imem_addr;
      lat_left    = $urandom_range(lat_min, lat_max);
    end
    if (xfer) begin
      $display("xfer pc=%h instr=%h", if_pc, if_instr);
      check("if_pc", if_pc, exp_pc);
      check("if_instr", if_instr, mem_word(exp_pc));
      check("if_pc_plus2", if_pc_plus2, exp_pc + 16'd2);
      if (cadence_on && last_xfer >= 0) check("cadence", 16'(cyc - last_xfer), 16'd3);
      last_xfer = cyc;
      n_xfer++;
      if (mem_word(exp_pc) >> 12 == 16'hF) exp_halted = 1'b1;
      else exp_pc = exp_pc + 16'd2;
    end
    if (rd) begin
      exp_pc     = rpc & 16'hFFFE;
      exp_halted = 1'b0;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 16'(imem_req), 16'h0);
    check({tag, "_valid"}, 16'(if_valid), 16'h0);
    check({tag, "_instr"}, if_instr, 16'h0);
    check({tag, "_pc"}, if_pc, 16'h0);
    check({tag, "_plus2"}, if_pc_plus2, 16'h0);
    check({tag, "_halted"}, 16'(halted), 16'h0);
  endtask

  initial begin
    logic [15:0] held_pc;
    logic [15:0] held_instr;
    int          start_x;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0; if_ready = 1'b0;
    exp_pc = 16'h0000; exp_halted = 1'b0; outstanding = 0; stray = 0;
    out_addr = 16'h0; lat_left = 0; lat_min = 0; lat_max = 0; gnt_pct = 100;
    last_grant = 0; cyc = 0; last_xfer = -1; cadence_on = 0; n_xfer = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Sequential zero-wait fetch: one delivery every 3 cycles.
    cadence_on = 1;
    start_x = n_xfer;
    repeat (12) cycle(1'b0, 16'h0, 1'b1);
    cadence_on = 0;
    check("seq_count", 16'(n_xfer - start_x), 16'd4);

    // Backpressure in HOLD.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 16'h0, 1'b0);
      if (if_valid) break;
    end
    check("bp_wait_valid", 16'(if_valid), 16'h1);
    held_pc = if_pc;
    held_instr = if_instr;
    repeat (5) begin
      cycle(1'b0, 16'h0, 1'b0);
      check("bp_valid", 16'(if_valid), 16'h1);
      check("bp_noreq", 16'(imem_req), 16'h0);
      check("bp_pc", if_pc, held_pc);
      check("bp_instr", if_instr, held_instr);
    end
    repeat (6) cycle(1'b0, 16'h0, 1'b1);

    // Redirect while a response is pending.
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 16'h0, 1'b1);
      if (last_grant) break;
    end
    check("wait_grant", 16'(last_grant), 16'h1);
    cycle(1'b1, 16'h0040, 1'b1);
    start_x = n_xfer;
    repeat (12) cycle(1'b0, 16'h0, 1'b1);
    check("rd_wait_progress", 16'(n_xfer > start_x), 16'h1);
    lat_min = 0; lat_max = 0;

    // Redirect in HOLD with ready high.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 16'h0, 1'b0);
      if (if_valid) break;
    end
    check("hold_wait_valid", 16'(if_valid), 16'h1);
    cycle(1'b1, 16'h0100, 1'b1);
    repeat (8) cycle(1'b0, 16'h0, 1'b1);

    // HLT at 0x007E, then release via redirect.
    cycle(1'b1, 16'h007A, 1'b1);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 16'h0, 1'b1);
      if (exp_halted) break;
    end
    cycle(1'b0, 16'h0, 1'b1);
    check("hlt_halted", 16'(halted), 16'h1);
    repeat (20) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h0020, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    check("hlt_release", 16'(halted), 16'h0);
    repeat (8) cycle(1'b0, 16'h0, 1'b1);

    // PC wrap at the top of the address space.
    cycle(1'b1, 16'hFFFC, 1'b1);
    repeat (12) cycle(1'b0, 16'h0, 1'b1);

    // Asynchronous reset in WAIT, released mid-cycle, stray response afterwards.
    lat_min = 6; lat_max = 6;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 16'h0, 1'b1);
      if (last_grant) break;
    end
    cycle(1'b0, 16'h0, 1'b1);
    #2;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    outstanding = 0; stray = 1; exp_pc = 16'h0000; exp_halted = 1'b0; last_xfer = -1;
    lat_min = 0; lat_max = 0;
    start_x = n_xfer;
    repeat (10) cycle(1'b0, 16'h0, 1'b1);
    check("post_rst_progress", 16'(n_xfer > start_x), 16'h1);

    // Randomized traffic.
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [15:0] t;
      rd = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) == 0) t = 16'hFFF8;
      else t = 16'($urandom_range(0, 255));
      cycle(rd, t, ($urandom_range(0, 99) < 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer of the next-PC value produced by branch/PC-increment logic.
- Owns the architectural PC register and fetches instruction words from instruction memory over a req/gnt/rvalid interface.
- Delivers each instruction with its PC and PC+2 to the IF/ID stage over a valid/ready handshake.
- Accepts redirects (taken B/BR) and stops fetching after a HLT instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, instr[15:12] value identifying HLT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- redirect  in  1  load redirect_pc and flush in-flight fetch
- redirect_pc  in  16  branch target (pc_next of a taken branch)
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address (byte address, bit 0 always 0)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  16  fetched instruction word
- if_valid  out  1  instruction available to IF/ID
- if_ready  in  1  IF/ID accepts this cycle
- if_instr  out  16  instruction word
- if_pc  out  16  address of if_instr
- if_pc_plus2  out  16  if_pc + 2, mod 2^16
- halted  out  1  HLT delivered; fetching stopped

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, drop=0.
  - if_instr/if_pc/if_pc_plus2=0; if_valid=0; halted=0; imem_req=0 while rst_n low.
- States: FETCH, WAIT, HOLD, HALTED. At most one outstanding memory request.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: latch req_pc=pc, go WAIT.
  - imem_req stays high until granted.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: capture if_instr=imem_rdata, if_pc=req_pc, if_pc_plus2=req_pc+2, go HOLD.
  - On imem_rvalid with drop=1: discard data, clear drop, go FETCH.
- HOLD:
  - if_valid = 1 & !redirect (combinational gating; no transfer occurs in a redirect cycle).
  - Transfer (if_valid & if_ready):
    - instr[15:12]==HLT_OPCODE: pc unchanged, go HALTED.
    - otherwise: pc <= if_pc+2, go FETCH.
  - Outputs held stable while if_ready=0.
- HALTED:
  - halted=1, imem_req=0, if_valid=0.
  - Stays in HALTED until redirect.
- Redirect has top priority in every state, one cycle:
  - pc <= redirect_pc; halted cleared; next state FETCH, except as below.
  - FETCH with imem_gnt same cycle: stale request; set drop=1, go WAIT.
  - WAIT without imem_rvalid: set drop=1, stay WAIT.
  - WAIT with imem_rvalid same cycle: discard data, go FETCH.
  - HOLD: buffered instruction abandoned.
- Arithmetic: 16-bit, wraps (16'hFFFE+2 = 16'h0000). redirect_pc bit 0 forced to 0.
- Throughput: zero-wait memory (gnt in FETCH, rvalid next cycle) plus if_ready=1 gives one instruction per 3 cycles.
- Reset mid-transaction: a late imem_rvalid arriving in FETCH is ignored.

Optional Feature:
- Macro IFETCH_STATS_EN.
- Defined: adds outputs stat_fetched[15:0] and stat_flushed[15:0].
  - stat_fetched: count of if_valid&if_ready transfers.
  - stat_flushed: count of discarded responses and abandoned HOLD instructions.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Sequential fetch: zero-wait memory returning 16'h1234, if_ready=1 -> deliveries at pc 0x0000, 0x0002, 0x0004, every 3 cycles; if_pc_plus2 = if_pc+2.
- Backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid stays 1 with if_instr/if_pc stable; no imem_req; pc advances only after the ready cycle.
- Redirect in WAIT: redirect_pc=0x0040 while awaiting a 0x0006 response, rvalid 2 cycles later -> response discarded, next imem_addr=0x0040, no delivery for 0x0006.
- Redirect in HOLD with if_ready=1 same cycle -> if_valid=0 that cycle (no transfer); next request at redirect_pc.
- HLT: imem_rdata=16'hF000 at pc 0x0010 -> delivered once, halted=1, no further imem_req for 20 cycles; then redirect to 0x0020 -> halted=0, fetch 0x0020.
- Async reset asserted in WAIT, released mid-cycle -> outputs 0 immediately; first imem_addr=RESET_PC; stray rvalid ignored.
